// File: rtl/div_subshift.sv
// div_subshift: sequential restoring shift-subtract divider.
// Produces one quotient bit per clock, signed (truncating) or unsigned.
// The control style matches the add-shift multiplier: hold en high to run,
// then done rises and the result is held while en stays high.
// Divide by zero gives quotient = all ones and remainder = dividend.
// Signed overflow (most negative / -1) gives quotient = most negative and
// remainder = 0 with no special-case logic.
module div_subshift #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sign,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int              PC_W    = $clog2(DATA_W + 2);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DATA_W + 1);

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] q_reg;     // dividend magnitude, becomes quotient magnitude
    logic [DATA_W-1:0] div_reg;   // divisor magnitude
    logic [DATA_W-1:0] rem_reg;   // partial remainder, always < divisor (or = dividend bits when divisor is 0)
    logic              neg_q;
    logic              neg_r;
    logic              zero_r;

    // Operand magnitudes for the start cycle. In signed mode, the most
    // negative value negates to itself, which reads correctly as an unsigned
    // magnitude.
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

    assign a_neg = sign & op_a[DATA_W-1];
    assign b_neg = sign & op_b[DATA_W-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // One restoring step. The shifted remainder is DATA_W+1 bits wide.
    // When the subtraction fits, the true difference is below the divisor,
    // so it can be computed modulo 2^DATA_W.
    logic [DATA_W:0]   shifted;
    logic              fits;
    logic [DATA_W-1:0] rem_sub;

    assign shifted = {rem_reg, q_reg[DATA_W-1]};
    assign fits    = (shifted >= {1'b0, div_reg});
    assign rem_sub = shifted[DATA_W-1:0] - div_reg;

    // Sign fix-up for the final cycle. A zero divisor leaves the quotient as
    // all ones, regardless of operand signs.
    logic [DATA_W-1:0] q_fixed;
    logic [DATA_W-1:0] r_fixed;

    assign q_fixed = (neg_q && !zero_r) ? -q_reg : q_reg;
    assign r_fixed = neg_r ? -rem_reg : rem_reg;

    // Sequencer: latch operands at pc=0, run DATA_W restoring steps, then fix signs and hold.
    // NOTE: every register is written with <= so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            q_reg       <= '0;
            div_reg     <= '0;
            rem_reg     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_r      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (!en) begin
            pc          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (pc == '0) begin
            q_reg   <= a_mag;
            div_reg <= b_mag;
            rem_reg <= '0;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            zero_r  <= (op_b == '0);
            pc      <= pc + PC_W'(1);
        end else if (pc != PC_LAST) begin
            rem_reg <= fits ? rem_sub : shifted[DATA_W-1:0];
            q_reg   <= {q_reg[DATA_W-2:0], fits};
            pc      <= pc + PC_W'(1);
        end else begin
            quotient    <= q_fixed;
            remainder   <= r_fixed;
            done        <= 1'b1;
            div_by_zero <= zero_r;
        end
    end

endmodule

// File: tb/tb_div_subshift.sv
// tb_div_subshift: directed vectors on a 32-bit divider, plus an 8-bit
// divider swept over a table of corner values against a reference model.
module tb_div_subshift;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        sign;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;

    logic        en8;
    logic        sign8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        done8;
    logic [7:0]  q8;
    logic [7:0]  r8;
    logic        dbz8;

    div_subshift #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .sign(sign), .done(done),
        .op_a(op_a), .op_b(op_b), .quotient(quotient), .remainder(remainder),
        .div_by_zero(dbz)
    );

    div_subshift #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .sign(sign8), .done(done8),
        .op_a(a8), .op_b(b8), .quotient(q8), .remainder(r8),
        .div_by_zero(dbz8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 32-bit run: clears, starts, scrambles operands after pc=0,
    // checks done is low at edge 33 and high at edge 34, then checks results.
    // The unit is left running with en high.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op_a = a;
        op_b = b;
        sign = s;
        en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_a = ~a;
        op_b = a ^ b ^ 32'h5A5A_0001;
        sign = ~s;
        repeat (32) @(posedge clk);
        #1 check({tag, " done@33"}, 64'(done), 64'(0));
        @(posedge clk);
        #1;
        check({tag, " done@34"}, 64'(done), 64'(1));
        check({tag, " q"}, 64'(quotient), 64'(eq));
        check({tag, " r"}, 64'(remainder), 64'(er));
        check({tag, " dbz"}, 64'(dbz), 64'(edbz));
    endtask

    function automatic logic [16:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic [7:0] q;
        logic [7:0] r;
        sa = a;
        sb = b;
        if (b == 8'h00) return {1'b1, 8'hFF, a};
        if (s) begin
            if (a == 8'h80 && b == 8'hFF) begin
                q = 8'h80;
                r = 8'h00;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [16:0] exp;
        exp = ref8(a, b, s);
        @(negedge clk);
        en8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a8    = a;
        b8    = b;
        sign8 = s;
        en8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8    = ~a;
        b8    = ~b;
        sign8 = ~s;
        repeat (9) @(posedge clk);
        #1;
        check($sformatf("w8 done s=%0d %0h/%0h", s, a, b), 64'(done8), 64'(1));
        check($sformatf("w8 res s=%0d %0h/%0h", s, a, b), 64'({dbz8, q8, r8}), 64'(exp));
    endtask

    logic [7:0] vals [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h10, 8'h13, 8'h3F, 8'h55, 8'h64,
                              8'h7E, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC0, 8'hF9, 8'hFD, 8'hFE, 8'hFF};

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        sign  = 1'b0;
        op_a  = '0;
        op_b  = '0;
        en8   = 1'b0;
        sign8 = 1'b0;
        a8    = '0;
        b8    = '0;
        #2;
        check("reset done", 64'(done), 64'(0));
        check("reset q", 64'(quotient), 64'(0));
        check("reset r", 64'(remainder), 64'(0));
        check("reset dbz", 64'(dbz), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run32("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold done", 64'(done), 64'(1));
        check("hold q", 64'(quotient), 64'(14));
        check("hold r", 64'(remainder), 64'(2));

        run32("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run32("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run32("u 5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run32("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        run32("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run32("u ovf ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        run32("u max/3", 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0);

        // Abort with en dropped while the unit holds a result.
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("abort done", 64'(done), 64'(0));
        check("abort q", 64'(quotient), 64'(0));
        check("abort r", 64'(remainder), 64'(0));

        // Abort mid-operation at pc=10, then run again from scratch.
        @(negedge clk);
        op_a = 32'd100;
        op_b = 32'd7;
        sign = 1'b0;
        en   = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("mid abort done", 64'(done), 64'(0));
        check("mid abort q", 64'(quotient), 64'(0));
        run32("rerun 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        // Asynchronous reset pulse between clock edges.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst done", 64'(done), 64'(0));
        check("async rst q", 64'(quotient), 64'(0));
        check("async rst r", 64'(remainder), 64'(0));
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 20; i++)
                for (int j = 0; j < 20; j++)
                    run8(vals[i], vals[j], s[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
